// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings, address constants and refresh FSM state encoding
// Shared by the init, auto-refresh and arbiter stages.
package sdram_pkg;

    localparam logic [3:0]  CMD_NOP          = 4'b0111;
    localparam logic [3:0]  CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0]  CMD_AUTO_REFRESH = 4'b0001;

    localparam logic [11:0] ADDR_ALL_BANKS   = 12'h400;
    localparam logic [11:0] ADDR_ZERO        = 12'h000;

    localparam logic [2:0]  ST_IDLE     = 3'd0;
    localparam logic [2:0]  ST_PRE      = 3'd1;
    localparam logic [2:0]  ST_WAIT_TRP = 3'd2;
    localparam logic [2:0]  ST_AREF     = 3'd3;
    localparam logic [2:0]  ST_WAIT_TRC = 3'd4;
    localparam logic [2:0]  ST_DONE     = 3'd5;

    // Command driven on the bus while the refresh FSM sits in a given state.
    function automatic logic [3:0] aref_state_cmd(input logic [2:0] st);
        case (st)
            ST_PRE:  aref_state_cmd = CMD_PRECHARGE;
            ST_AREF: aref_state_cmd = CMD_AUTO_REFRESH;
            default: aref_state_cmd = CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sdram_aref.sv
// rtl/sdram_aref.sv - SDRAM auto-refresh stage: interval timer, request/grant, PRECHARGE ALL + AUTO REFRESH burst
// Optional sticky overrun flag under SDRAM_AREF_OVERRUN_EN.
module sdram_aref
    import sdram_pkg::*;
#(
    parameter int REF_PERIOD = 780,
    parameter int TRP_CLK    = 2,
    parameter int TRC_CLK    = 7,
    parameter int AREF_NUM   = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        flag_init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [11:0] aref_addr,
    output logic        flag_aref_end
`ifdef SDRAM_AREF_OVERRUN_EN
    ,
    output logic        aref_overrun
`endif
);

    localparam int TW       = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int WAIT_MAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
    localparam int WW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(REF_PERIOD - 1);
    localparam logic [WW-1:0] TRP_LAST   = WW'((TRP_CLK > 0) ? TRP_CLK - 1 : 0);
    localparam logic [WW-1:0] TRC_LAST   = WW'((TRC_CLK > 0) ? TRC_CLK - 1 : 0);
    localparam logic [2:0]    REF_TOTAL  = 3'(AREF_NUM);
    localparam logic [2:0]    REF_LAST   = 3'(AREF_NUM - 1);

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [WW-1:0] r_wait;
    logic [2:0]    r_ref_cnt;
    logic          r_aref_req;
    logic [3:0]    r_cmd;
    logic [11:0]   r_addr;
    logic          r_end;

    logic          w_wrap;
    logic          w_accept;
    logic [2:0]    w_next_state;

    assign w_wrap   = flag_init_end && (r_timer == TIMER_LAST);
    assign w_accept = (r_state == ST_IDLE) && r_aref_req && aref_en;

    // Interval timer is independent of grants so refreshes stay evenly spaced.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_timer <= '0;
        end else if (!flag_init_end || w_wrap) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // A wrap coinciding with an accept keeps the request high for the next interval.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_aref_req <= 1'b0;
        end else if (w_wrap) begin
            r_aref_req <= 1'b1;
        end else if (w_accept) begin
            r_aref_req <= 1'b0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_PRE;
                end
            end
            ST_PRE: begin
                w_next_state = (TRP_CLK == 0) ? ST_AREF : ST_WAIT_TRP;
            end
            ST_WAIT_TRP: begin
                if (r_wait == TRP_LAST) begin
                    w_next_state = ST_AREF;
                end
            end
            ST_AREF: begin
                if (TRC_CLK != 0) begin
                    w_next_state = ST_WAIT_TRC;
                end else if (r_ref_cnt == REF_LAST) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_AREF;
                end
            end
            ST_WAIT_TRC: begin
                if (r_wait == TRC_LAST) begin
                    w_next_state = (r_ref_cnt == REF_TOTAL) ? ST_DONE : ST_AREF;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wait <= '0;
        end else if (w_next_state != r_state) begin
            r_wait <= '0;
        end else if (r_state == ST_WAIT_TRP || r_state == ST_WAIT_TRC) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ref_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_ref_cnt <= '0;
        end else if (r_state == ST_AREF) begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cmd  <= CMD_NOP;
            r_addr <= ADDR_ZERO;
            r_end  <= 1'b0;
        end else begin
            r_cmd  <= aref_state_cmd(w_next_state);
            r_addr <= (w_next_state == ST_PRE) ? ADDR_ALL_BANKS : ADDR_ZERO;
            r_end  <= (w_next_state == ST_DONE);
        end
    end

    assign aref_req      = r_aref_req;
    assign aref_cmd      = r_cmd;
    assign aref_addr     = r_addr;
    assign flag_aref_end = r_end;

`ifdef SDRAM_AREF_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_wrap && r_aref_req && !w_accept) begin
            r_overrun <= 1'b1;
        end
    end

    assign aref_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_sdram_aref.sv
// tb/tb_sdram_aref.sv - randomized bench for sdram_aref against a schedule-level reference model
module tb_sdram_aref;

    localparam int REF  = 780;
    localparam int TRP  = 2;
    localparam int TRC  = 7;
    localparam int NREF = 2;
    localparam int SEQ_LEN = 1 + TRP + NREF * (1 + TRC) + 1;

    localparam logic [3:0]  NOP  = 4'b0111;
    localparam logic [3:0]  PREA = 4'b0010;
    localparam logic [3:0]  AREF = 4'b0001;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        flag_init_end;
    logic        aref_en;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;
    logic        flag_aref_end;
`ifdef SDRAM_AREF_OVERRUN_EN
    logic        aref_overrun;
`endif

    sdram_aref dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .flag_init_end (flag_init_end),
        .aref_en       (aref_en),
        .aref_req      (aref_req),
        .aref_cmd      (aref_cmd),
        .aref_addr     (aref_addr),
        .flag_aref_end (flag_aref_end)
`ifdef SDRAM_AREF_OVERRUN_EN
        ,
        .aref_overrun  (aref_overrun)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int m_timer;
    int m_pos;
    bit m_req;
    bit m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_cmd(input int pos);
        logic [3:0] c;
        c = NOP;
        if (pos == 1) c = PREA;
        for (int j = 0; j < NREF; j++) begin
            if (pos == 2 + TRP + j * (1 + TRC)) c = AREF;
        end
        return c;
    endfunction

    task automatic check_outputs(input string ph);
        chk({ph, "_cmd"},  32'(aref_cmd),      32'(exp_cmd(m_pos)));
        chk({ph, "_addr"}, 32'(aref_addr),     (m_pos == 1) ? 32'h400 : 32'h0);
        chk({ph, "_req"},  32'(aref_req),      32'(m_req));
        chk({ph, "_end"},  32'(flag_aref_end), 32'(m_pos == SEQ_LEN));
`ifdef SDRAM_AREF_OVERRUN_EN
        chk({ph, "_ovr"},  32'(aref_overrun),  32'(m_ovr));
`endif
    endtask

    task automatic model_reset();
        m_timer = 0;
        m_pos   = 0;
        m_req   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic step(input string ph, input bit init, input bit en);
        bit wrap;
        bit acc;
        flag_init_end = init;
        aref_en       = en;
        wrap = init && (m_timer == REF - 1);
        acc  = (m_pos == 0) && m_req && en;
        if (wrap && m_req && !acc) m_ovr = 1'b1;
        m_req   = wrap ? 1'b1 : (acc ? 1'b0 : m_req);
        m_timer = (!init || wrap) ? 0 : m_timer + 1;
        m_pos   = acc ? 1 : ((m_pos == 0 || m_pos == SEQ_LEN) ? 0 : m_pos + 1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        check_outputs(ph);
    endtask

    task automatic do_reset(input string ph);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs({ph, "_async"});
        @(negedge sys_clk);
        check_outputs({ph, "_held"});
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int k;
        bit found;
        bit r_init;

        sys_rst_n     = 1'b0;
        flag_init_end = 1'b0;
        aref_en       = 1'b0;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_outputs("reset");
        sys_rst_n = 1'b1;

        for (int i = 0; i < 5000; i++) step("no_init", 1'b0, 1'($urandom_range(0, 1)));

        k = 0;
        found = 1'b0;
        while (!found && k < 2000) begin
            step("first_req", 1'b1, 1'b1);
            k++;
            if (aref_req) found = 1'b1;
        end
        chk("first_req_latency", 32'(k), 32'(REF));
        for (int i = 0; i < SEQ_LEN + 5; i++) step("first_seq", 1'b1, 1'b1);

        k = 0;
        while (!m_req && k < 2 * REF) begin
            step("hold_wait", 1'b1, 1'b0);
            k++;
        end
        chk("hold_req_seen", 32'(aref_req), 32'h1);
        for (int i = 0; i < 300; i++) step("hold", 1'b1, 1'b0);
        step("grant_pulse", 1'b1, 1'b1);
        chk("grant_pulse_req_drop", 32'(aref_req), 32'h0);
        for (int i = 0; i < SEQ_LEN + 5; i++) step("late_seq", 1'b1, 1'b0);

        k = 0;
        while (!(m_req && m_pos == 0 && m_timer == REF - 1) && k < 3 * REF) begin
            step("wrap_wait", 1'b1, 1'b0);
            k++;
        end
        chk("wrap_wait_found", 32'(m_timer == REF - 1), 32'h1);
        step("wrap_accept", 1'b1, 1'b1);
        chk("wrap_accept_req", 32'(aref_req), 32'h1);
        for (int i = 0; i < SEQ_LEN + 3; i++) step("wrap_seq", 1'b1, 1'b0);
        chk("wrap_req_kept", 32'(aref_req), 32'h1);

        do_reset("ovr_rst");
        for (int i = 0; i < 1600; i++) step("overrun", 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) step("overrun_grant", 1'b1, 1'b1);
`ifdef SDRAM_AREF_OVERRUN_EN
        chk("overrun_sticky", 32'(aref_overrun), 32'h1);
`endif

        r_init = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 499) == 0) r_init = ~r_init;
            step("random", r_init, ($urandom_range(0, 7) == 0));
        end

        do_reset("trc_rst");
        k = 0;
        while (m_pos != 3 + TRP + 3 && k < 2 * REF) begin
            step("trc_wait", 1'b1, 1'b1);
            k++;
        end
        chk("trc_reached", 32'(m_pos), 32'(3 + TRP + 3));
        do_reset("trc_abort");
        for (int i = 0; i < REF + SEQ_LEN + 10; i++) step("post_abort", 1'b1, 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_aref.md
Name: sdram_aref

Overview:
Auto-refresh stage downstream of SDRAM power-up initialisation. It starts once initialisation completes (flag_init_end high) and keeps a refresh-interval timer running. Each interval it raises a refresh request to the command arbiter. When granted, it issues PRECHARGE ALL followed by AREF_NUM AUTO REFRESH commands with tRP/tRC spacing. Its cmd/addr outputs are muxed by the arbiter onto {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} and sdram_addr.

Parameters:
REF_PERIOD, 780, refresh interval in sys_clk cycles (64 ms / 4096 rows at 50 MHz, with margin)
TRP_CLK, 2, NOP cycles after PRECHARGE (tRP)
TRC_CLK, 7, NOP cycles after each AUTO REFRESH (tRC)
AREF_NUM, 2, AUTO REFRESH commands per grant (1..4)

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
flag_init_end  input  1  level; high once initialisation sequence finished
aref_en  input  1  grant from arbiter; sampled only in IDLE while aref_req=1
aref_req  output  1  registered refresh request to arbiter
aref_cmd  output  4  registered {cs_n,ras_n,cas_n,we_n}
aref_addr  output  12  registered SDRAM address
flag_aref_end  output  1  one-cycle pulse: sequence complete, bus released

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE; timer=0; aref_req=0; aref_cmd=NOP (4'b0111); aref_addr=12'h000; flag_aref_end=0. Reset mid-sequence aborts immediately; outputs go to NOP at once.
- Interval timer: held at 0 while flag_init_end=0. Otherwise free-runs 0..REF_PERIOD-1 and wraps; it is not restarted by grants. Wrap = cycle with timer==REF_PERIOD-1.
- aref_req: set on wrap; cleared in the accept cycle (IDLE & aref_req & aref_en). If wrap and accept coincide, aref_req stays 1 (new interval pending).
- FSM states: IDLE, PRE, WAIT_TRP, AREF, WAIT_TRC, DONE.
  - IDLE -> PRE on accept.
  - PRE (1 cycle): aref_cmd=PRECHARGE 4'b0010, aref_addr=12'h400 (A10=1, all banks).
  - WAIT_TRP: TRP_CLK cycles of NOP -> AREF.
  - AREF (1 cycle): aref_cmd=AUTO_REFRESH 4'b0001; increments refresh counter.
  - WAIT_TRC: TRC_CLK cycles of NOP. Then -> AREF if count<AREF_NUM, else -> DONE.
  - DONE (1 cycle): flag_aref_end=1, NOP; then -> IDLE.
- Timing from accept cycle T (defaults): PRE T+1; NOP T+2..T+3; AREF T+4; NOP T+5..T+11; AREF T+12; NOP T+13..T+19; flag_aref_end T+20. General length = 1+TRP_CLK+AREF_NUM*(1+TRC_CLK)+1 cycles.
- aref_addr returns to 12'h000 in every cycle except PRE.
- aref_en outside IDLE, or with aref_req=0, is ignored.
- flag_init_end falling affects only the timer; an in-flight sequence completes.

Optional Feature:
Macro SDRAM_AREF_OVERRUN_EN.
- Defined: adds output aref_overrun (1 bit, reset 0). It sets sticky when a wrap occurs while aref_req is already 1 and not being accepted that cycle. Cleared only by reset.
- Undefined: no port and no logic; that wrap is silently absorbed, with aref_req staying 1.

Decomposition:
- Package sdram_pkg holds the 4-bit command encodings (NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001), the A10 all-banks address constant 12'h400, and the FSM state encoding. It is shared with sdram_init and the arbiter.
- No sub-module: timer, wait counter and refresh counter are inline.

Test Plan:
- Reset then flag_init_end=1 at cycle 0, aref_en tied 1 -> aref_req rises after 780 cycles; sequence exactly PRE/NOP×2/AREF/NOP×7/AREF/NOP×7; flag_aref_end one cycle at T+20; aref_addr=12'h400 only in the PRE cycle.
- flag_init_end held 0 for 5000 cycles -> aref_req stays 0, aref_cmd stays 4'b0111.
- aref_en held 0 for 300 cycles after aref_req rises, then pulsed 1 for one cycle -> aref_req holds, drops the next cycle, and the sequence starts at T+1.
- aref_en asserted exactly at a wrap cycle -> sequence starts and aref_req remains 1 afterwards.
- sys_rst_n pulsed low during WAIT_TRC -> outputs asynchronously reset to NOP/0; after release no command until the next request and grant.
- SDRAM_AREF_OVERRUN_EN defined, aref_en=0 for 1600 cycles -> aref_overrun=1 at the second wrap and stays 1 after a later grant.
